// File: rtl/mod_symbol_sequencer_if.sv
// Symbol write port shared between the producer and the sequencer FIFO.
// The producer drives data and valid; the sequencer answers with ready.
interface mod_symbol_sequencer_if;
  logic       sym_valid;
  logic [2:0] sym_data;
  logic       sym_last;
  logic       sym_ready;

  modport master (output sym_valid, sym_data, sym_last, input sym_ready);
  modport slave  (input sym_valid, sym_data, sym_last, output sym_ready);
endinterface

// File: rtl/mod_symbol_sequencer.sv
// Symbol sequencer: queues modulation symbols and paces them to a sine
// generator, one symbol every SYM_LEN clocks, with phase/frequency mapping.
module mod_symbol_sequencer #(
  parameter int unsigned SYM_LEN    = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [1:0]                    mod_type,
  input  logic [1:0]                    cfg_freq0,
  input  logic [1:0]                    cfg_freq1,
  mod_symbol_sequencer_if.slave         sym,
  output logic [1:0]                    samp_freq,
  output logic [2:0]                    phase_sh,
  output logic                          gen_load,
  output logic                          amp_en,
  output logic                          busy,
  output logic                          done,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(SYM_LEN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SYM_LEN - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    MOD_BPSK = 2'b00,
    MOD_QPSK = 2'b01,
    MOD_8PSK = 2'b10,
    MOD_BFSK = 2'b11
  } mod_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN
  } state_e;

  function automatic logic [2:0] map_phase(input mod_e m, input logic [2:0] d);
    case (m)
      MOD_BPSK: return {d[0], 2'b00};
      MOD_QPSK: return {d[1:0], 1'b0};
      MOD_8PSK: return d;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] map_freq(input mod_e m, input logic d0,
                                          input logic [1:0] f0, input logic [1:0] f1);
    return (m == MOD_BFSK && d0) ? f1 : f0;
  endfunction

  state_e         state_q, state_d;
  mod_e           mod_q, mod_d;
  logic [1:0]     f0_q, f0_d, f1_q, f1_d;
  logic [1:0]     freq_q, freq_d;
  logic [2:0]     phase_q, phase_d;
  logic           gen_load_q, gen_load_d;
  logic           done_q, done_d;
  logic           underrun_q, underrun_d;
  logic           last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [3:0]     fifo_mem [FIFO_DEPTH];
  logic [3:0]     head;
  logic           push, pop, load, fifo_nonempty;

  assign head          = fifo_mem[rd_ptr_q];
  assign fifo_nonempty = (count_q != '0);
  assign sym.sym_ready = (count_q != FULL_CNT);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    mod_d      = mod_q;
    f0_d       = f0_q;
    f1_d       = f1_q;
    freq_d     = freq_q;
    phase_d    = phase_q;
    gen_load_d = 1'b0;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    push       = sym.sym_valid && sym.sym_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mod_d      = mod_e'(mod_type);
          f0_d       = cfg_freq0;
          f1_d       = cfg_freq1;
          underrun_d = 1'b0;
          if (fifo_nonempty) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (fifo_nonempty) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (fifo_nonempty) begin
          load = 1'b1;
        end else begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          underrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Config comes from mod_d/f*_d so a start that pops immediately uses the fresh settings.
    if (load) begin
      phase_d    = map_phase(mod_d, head[2:0]);
      freq_d     = map_freq(mod_d, head[0], f0_d, f1_d);
      gen_load_d = 1'b1;
      cnt_d      = CNT_LOAD;
      last_d     = head[3];
    end
    pop = load;

    // Abort outranks everything; generator config and underrun are kept.
    if (abort) begin
      state_d    = ST_IDLE;
      mod_d      = mod_q;
      f0_d       = f0_q;
      f1_d       = f1_q;
      freq_d     = freq_q;
      phase_d    = phase_q;
      gen_load_d = 1'b0;
      done_d     = 1'b0;
      underrun_d = underrun_q;
      last_d     = 1'b0;
      cnt_d      = '0;
      push       = 1'b0;
      pop        = 1'b0;
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {sym.sym_last, sym.sym_data};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mod_q      <= MOD_BPSK;
      f0_q       <= '0;
      f1_q       <= '0;
      freq_q     <= '0;
      phase_q    <= '0;
      gen_load_q <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mod_q      <= mod_d;
      f0_q       <= f0_d;
      f1_q       <= f1_d;
      freq_q     <= freq_d;
      phase_q    <= phase_d;
      gen_load_q <= gen_load_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign samp_freq  = freq_q;
  assign phase_sh   = phase_q;
  assign gen_load   = gen_load_q;
  assign done       = done_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q == ST_RUN);
  assign amp_en     = (state_q == ST_RUN);
  assign fifo_count = count_q;

endmodule

// File: doc/mod_symbol_sequencer.md
MOD_SYMBOL_SEQUENCER -- requirements
Module: mod_symbol_sequencer

Interface
REQ-001 SHALL have parameter SYM_LEN, default 1024, meaning clk cycles per symbol (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning symbol FIFO entries (power of two, at least 2).
REQ-003 SHALL have clk, input, 1 bit, meaning system clock; all state changes on its rising edge.
REQ-004 SHALL have reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-005 SHALL have start, input, 1, meaning single-cycle request to begin a transmission.
REQ-006 SHALL have abort, input, 1, meaning synchronous stop and FIFO flush.
REQ-007 SHALL have mod_type, input, 2, meaning 00 BPSK, 01 QPSK, 10 8PSK, 11 BFSK.
REQ-008 SHALL have cfg_freq0 and cfg_freq1, inputs, 2 each, meaning sine-generator step-size codes (PSK carrier uses freq0; BFSK uses freq0/freq1).
REQ-009 SHALL have sym_valid, input, 1; sym_data, input, 3; and sym_last, input, 1, meaning symbol write port.
REQ-010 SHALL have sym_ready, output, 1, meaning FIFO not full.
REQ-011 SHALL have samp_freq, output, 2, and phase_sh, output, 3, meaning registered configuration to the sine generator.
REQ-012 SHALL have gen_load, output, 1, meaning one-cycle pulse on the first cycle of each symbol, used to reload the generator phase.
REQ-013 SHALL have amp_en, busy, done, and underrun, outputs, 1 each; and fifo_count, output, log2(FIFO_DEPTH)+1 bits.

Function
REQ-014 SHALL store {sym_last, sym_data} in FIFO on the cycle sym_valid && sym_ready; sym_ready = (fifo_count != FIFO_DEPTH).
REQ-015 SHALL pop only when the registered fifo_count is non-zero; a word pushed into an empty FIFO is poppable the next cycle.
REQ-016 SHALL support simultaneous push and pop, with fifo_count unchanged.
REQ-017 SHALL implement states IDLE, ARM, and RUN.
REQ-018 In IDLE, start SHALL latch mod_type, cfg_freq0, and cfg_freq1. If the FIFO is non-empty, it SHALL go to RUN with the first symbol loaded; otherwise it SHALL go to ARM.
REQ-019 In IDLE, start SHALL clear underrun.
REQ-020 In ARM, the block SHALL pop and load the first symbol into RUN when the FIFO is non-empty.
REQ-021 start in ARM or RUN SHALL be ignored.
REQ-022 A symbol load SHALL register phase_sh, samp_freq, and gen_load=1 on the pop edge, and load the down-counter with SYM_LEN-1.
REQ-023 gen_load SHALL be 0 on all other cycles.
REQ-024 Phase mapping SHALL be as follows.
- BPSK: phase_sh={d[0],2'b00}.
- QPSK: phase_sh={d[1:0],1'b0}.
- 8PSK: phase_sh=d[2:0].
- BFSK: phase_sh=0.
REQ-025 samp_freq SHALL be the latched freq0 for PSK modes, and (d[0] ? freq1 : freq0) for BFSK.
REQ-026 In RUN the counter SHALL decrement each cycle, so each symbol occupies exactly SYM_LEN cycles measured from gen_load.
REQ-027 When the count reaches 0 in RUN, the block SHALL act as follows.
- If the current symbol had sym_last: go to IDLE with done=1 for one cycle.
- Else if the FIFO is non-empty: pop and load the next symbol back-to-back, with no gap cycle.
- Else: go to IDLE with underrun=1 (sticky) and done=1 for one cycle.
REQ-028 busy and amp_en SHALL be 1 exactly when state is RUN.
REQ-029 phase_sh and samp_freq SHALL hold their last values in IDLE and ARM.
REQ-030 abort SHALL force IDLE and empty the FIFO on the next edge from any state, with done=0 and underrun unchanged.
REQ-031 abort SHALL take priority over start, push, and pop in the same cycle.
REQ-032 The counter SHALL be wide enough for SYM_LEN-1 and SHALL never wrap below 0.

Reset
REQ-033 reset SHALL force the following immediately: state IDLE, FIFO empty (fifo_count=0, sym_ready=1), phase_sh=0, samp_freq=0, gen_load=0, amp_en=0, busy=0, done=0, underrun=0, counter=0.
REQ-034 reset asserted mid-symbol SHALL discard the current symbol and all queued symbols, and SHALL produce no done pulse.

Verification (SYM_LEN=4, FIFO_DEPTH=8)
REQ-035 QPSK with symbols 3,1,2(last) pushed, then start: expect gen_load at cycles t, t+4, t+8; phase_sh 6, 2, 4; done at t+12; busy low after.
REQ-036 BFSK with freq0=00, freq1=11, symbols 1,0(last): expect samp_freq 11 then 00, phase_sh 0, and two 4-cycle symbols.
REQ-037 start with the FIFO empty, then 5 idle cycles, then push symbol 4 with last, in 8PSK: expect ARM hold, RUN on the cycle after the push, phase_sh=4.
REQ-038 Two non-last symbols with no refill: expect underrun=1 and done pulse at the end of the 2nd symbol. A following start clears underrun.
REQ-039 Push 9 symbols while idle: 9th rejected with sym_ready=0 at fifo_count=8. Then abort mid-RUN: IDLE and fifo_count=0 the next cycle, no done.
REQ-040 Assert reset during the 2nd symbol: all outputs reach reset values immediately; start after release with an empty FIFO enters ARM.
